// File: rtl/mac_array_stream.sv
// Streaming signed multiply-accumulate array: LANES lanes each build one dot
// product per vector and hold the result on a valid/ready port until consumed.
module mac_array_stream #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 16,
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned CW      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  sat_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   in_w,
  input  logic [LANES*DW-1:0]   in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*AW-1:0]   out_data,
  output logic [LANES-1:0]      out_ovf,
  output logic [CW-1:0]         out_count,
  output logic                  out_trunc
);

  localparam int unsigned PW = 2 * DW;
  localparam logic signed [AW-1:0] SMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q [LANES];
  logic signed [AW-1:0]   acc_d [LANES];
  logic [LANES-1:0]       ovf_q, ovf_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   trunc_q, trunc_d;
  logic                   sat_q, sat_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;

  logic                   first_c;
  logic                   sat_eff_c;
  logic [CW-1:0]          cnt_inc_c;
  logic                   at_max_c;
  logic [LANES-1:0]       lane_ovf_c;
  logic signed [AW-1:0]   lane_res_c [LANES];

  assign first_c   = (cnt_q == '0);
  assign sat_eff_c = first_c ? sat_en : sat_q;
  assign cnt_inc_c = cnt_q + CW'(1);
  assign at_max_c  = (cnt_inc_c == CW'(MAX_LEN));

  // Per-lane product, AW+1-bit sum, overflow detect and wrap/saturate select.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DW-1:0] w_l, x_l;
    logic signed [PW-1:0] prod;
    logic signed [AW:0]   base, sum;

    assign w_l  = in_w[g*DW +: DW];
    assign x_l  = in_x[g*DW +: DW];
    assign prod = PW'(w_l) * PW'(x_l);
    assign base = first_c ? '0 : (AW+1)'(acc_q[g]);
    assign sum  = (AW+1)'(prod) + base;
    assign lane_ovf_c[g] = sum[AW] ^ sum[AW-1];
    assign lane_res_c[g] = (lane_ovf_c[g] && sat_eff_c) ? (sum[AW] ? SMIN : SMAX)
                                                          : sum[AW-1:0];
    assign out_data[g*AW +: AW] = acc_q[g];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    sat_d   = sat_q;
    for (int i = 0; i < LANES; i++) acc_d[i] = acc_q[i];

    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          for (int i = 0; i < LANES; i++) acc_d[i] = lane_res_c[i];
          ovf_d   = (first_c ? '0 : ovf_q) | lane_ovf_c;
          sat_d   = sat_eff_c;
          cnt_d   = cnt_inc_c;
          trunc_d = at_max_c && !in_last;
          if (in_last || at_max_c) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      default: state_d = ACCUM;
    endcase

    // Abort wins over any beat or handshake in the same cycle.
    if (clear) begin
      state_d = ACCUM;
      ovf_d   = '0;
      cnt_d   = '0;
      trunc_d = 1'b0;
      sat_d   = 1'b0;
      for (int i = 0; i < LANES; i++) acc_d[i] = '0;
    end

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      ovf_q       <= '0;
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      trunc_q     <= trunc_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < LANES; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_mac_array_stream.sv
// Bench for mac_array_stream: directed cases plus random traffic against an
// integer-arithmetic vector model.
module tb_mac_array_stream;

  localparam int LANES = 4, DW = 8, AW = 16, MAX_LEN = 4, CW = 3;

  logic                clk = 1'b0;
  logic                rst_n, clear, sat_en, in_valid, in_ready, in_last;
  logic [LANES*DW-1:0] in_w, in_x;
  logic                out_valid, out_ready;
  logic [LANES*AW-1:0] out_data;
  logic [LANES-1:0]    out_ovf;
  logic [CW-1:0]       out_count;
  logic                out_trunc;

  mac_array_stream #(.LANES(LANES), .DW(DW), .AW(AW), .MAX_LEN(MAX_LEN), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .sat_en(sat_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_w(in_w), .in_x(in_x), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_count(out_count), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Vector-level model: running dot products as plain integers.
  int m_acc [LANES];
  bit m_ovf [LANES];
  int m_cnt;
  bit m_sat, m_hold, m_trunc, m_wiped;

  function automatic void model_reset();
    for (int i = 0; i < LANES; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
    m_cnt = 0; m_sat = 0; m_hold = 0; m_trunc = 0;
  endfunction

  function automatic void model_beat(input logic [31:0] w, input logic [31:0] x,
                                     input bit last, input bit sat);
    bit first = (m_cnt == 0);
    if (first) m_sat = sat;
    for (int i = 0; i < LANES; i++) begin
      int wi = $signed(w[i*8 +: 8]);
      int xi = $signed(x[i*8 +: 8]);
      int s  = (first ? 0 : m_acc[i]) + wi * xi;
      bit o  = (s > 32767) || (s < -32768);
      if (o) s = m_sat ? ((s > 0) ? 32767 : -32768) : (((s + 32768) & 65535) - 32768);
      m_acc[i] = s;
      m_ovf[i] = (first ? 1'b0 : m_ovf[i]) | o;
    end
    m_cnt++;
    m_trunc = (m_cnt == MAX_LEN) && !last;
    if (last || m_cnt == MAX_LEN) m_hold = 1;
  endfunction

  function automatic logic [63:0] exp_data();
    logic [63:0] d;
    for (int i = 0; i < LANES; i++) d[i*16 +: 16] = 16'(m_acc[i]);
    return d;
  endfunction

  function automatic logic [3:0] exp_ovf();
    logic [3:0] o;
    for (int i = 0; i < LANES; i++) o[i] = m_ovf[i];
    return o;
  endfunction

  task automatic compare_all();
    check("in_ready", 64'(in_ready), 64'(!m_hold));
    check("out_valid", 64'(out_valid), 64'(m_hold));
    if (m_hold || m_wiped) begin
      check("out_data", out_data, exp_data());
      check("out_ovf", 64'(out_ovf), 64'(exp_ovf()));
      check("out_count", 64'(out_count), 64'(m_cnt));
      check("out_trunc", 64'(out_trunc), 64'(m_trunc));
    end
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit v, input bit last, input bit sat,
                       input logic [31:0] w, input logic [31:0] x,
                       input bit ordy, input bit clr, input bit rn);
    rst_n = rn; clear = clr; in_valid = v; in_last = last; sat_en = sat;
    in_w = w; in_x = x; out_ready = ordy;
    m_wiped = !rn || clr;
    if (m_wiped) model_reset();
    else if (!m_hold) begin
      if (v) model_beat(w, x, last, sat);
    end else if (ordy) begin
      m_hold = 0; m_cnt = 0;
    end
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle(input bit ordy);
    cycle(0, 0, 0, 32'h0, 32'h0, ordy, 0, 1);
  endtask

  int vcount;
  logic [31:0] rw, rx;

  initial begin
    model_reset();
    m_wiped = 0;
    cycle(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    cycle(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    idle(0);

    // Basic 3-beat dot product, then 5 stalled cycles with in_valid high.
    for (int b = 0; b < 3; b++) cycle(1, b == 2, 0, 32'hFEFEFE03, 32'h05050504, 0, 0, 1);
    check("t1_lane0", 64'(out_data[15:0]), 64'd36);
    check("t1_lane1", 64'(out_data[31:16]), 64'(16'hFFE2));
    for (int b = 0; b < 5; b++) cycle(1, 0, 0, 32'h01010101, 32'h01010101, 0, 0, 1);
    check("t1_count_held", 64'(out_count), 64'd3);
    cycle(1, 0, 0, 32'h01010101, 32'h01010101, 1, 0, 1);
    check("t1_ready_after", 64'(in_ready), 64'd1);

    // Saturating then wrapping overflow.
    for (int b = 0; b < 3; b++) cycle(1, b == 2, 1, 32'h0000807F, 32'h00007F7F, 0, 0, 1);
    check("sat_lane0", 64'(out_data[15:0]), 64'(16'h7FFF));
    check("sat_lane1", 64'(out_data[31:16]), 64'(16'h8000));
    check("sat_ovf", 64'(out_ovf), 64'(4'b0011));
    idle(1);
    for (int b = 0; b < 3; b++) cycle(1, b == 2, 0, 32'h0000807F, 32'h00007F7F, 0, 0, 1);
    check("wrap_lane0", 64'(out_data[15:0]), 64'(16'hBD03));
    check("wrap_lane1", 64'(out_data[31:16]), 64'(16'h4180));
    idle(1);

    // Length limit: six beats, no in_last until the sixth.
    for (int b = 0; b < 4; b++) cycle(1, 0, 0, 32'h01010101, 32'h01010101, 0, 0, 1);
    check("trunc_lane0", 64'(out_data[15:0]), 64'd4);
    check("trunc_flag", 64'(out_trunc), 64'd1);
    cycle(1, 0, 0, 32'h01010101, 32'h01010101, 1, 0, 1);
    cycle(1, 0, 0, 32'h01010101, 32'h01010101, 0, 0, 1);
    cycle(1, 1, 0, 32'h01010101, 32'h01010101, 0, 0, 1);
    check("trunc_tail_count", 64'(out_count), 64'd2);
    idle(1);

    // Abort by clear, then by reset.
    for (int r = 0; r < 2; r++) begin
      cycle(1, 0, 0, 32'h05050505, 32'h05050505, 0, 0, 1);
      cycle(1, 0, 0, 32'h05050505, 32'h05050505, 0, 0, 1);
      if (r == 0) cycle(1, 1, 0, 32'h05050505, 32'h05050505, 0, 1, 1);
      else begin
        cycle(1, 1, 0, 32'h05050505, 32'h05050505, 0, 0, 0);
        check("rst_data_zero", out_data, 64'h0);
      end
      cycle(1, 1, 0, 32'h01010101, 32'h02020202, 0, 0, 1);
      check("abort_lane0", 64'(out_data[15:0]), 64'd2);
      check("abort_count", 64'(out_count), 64'd1);
      idle(1);
    end

    // Single-beat vector of (-1)*(-1).
    cycle(1, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1);
    check("single_data", out_data, 64'h0001000100010001);
    idle(1);

    // Back-to-back 2-beat vectors with out_ready tied high.
    vcount = 0;
    for (int c = 0; c < 9; c++) begin
      cycle(1, m_cnt == 1, 0, 32'h02020202, 32'h03030303, 1, 0, 1);
      if (out_valid) vcount++;
    end
    check("b2b_results", 64'(vcount), 64'd3);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rw = $urandom; rx = $urandom;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'($urandom),
            rw, rx, $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0, $urandom_range(0, 79) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_array_stream.md
Name: mac_array_stream

Overview:
- Parametrised streaming multiply-accumulate array. LANES independent signed MAC lanes each compute one dot product per vector.
- Operands arrive one beat per handshake, with a last-beat marker. The completed result vector is held on a valid/ready output until it is consumed.
- Successor to the fixed 4-lane MAC array. Adds parametric width and lane count, flow control, a saturation mode, overflow flags, and a length limit.
- Sits between the operand fetch logic and the result writeback logic in the matrix datapath.

Parameters:
- LANES, 4, number of parallel MAC lanes.
- DW, 8, signed operand width (w and x).
- AW, 16, signed accumulator and result width; must be at least 2*DW.
- MAX_LEN, 256, maximum number of beats per vector before forced termination.
- CW, $clog2(MAX_LEN+1), width of the beat counter.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous abort: discards the current vector and its held result.
- sat_en  in  1  1 = saturating accumulate, 0 = wrap-around; sampled on the first beat of each vector.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  array can accept a beat.
- in_last  in  1  final beat of the current vector.
- in_w  in  LANES*DW  packed signed weights; lane i is at [i*DW +: DW].
- in_x  in  LANES*DW  packed signed activations; same packing as in_w.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  LANES*AW  packed signed results; lane i is at [i*AW +: AW].
- out_ovf  out  LANES  per-lane overflow flag for this vector (sticky across the vector).
- out_count  out  CW  number of beats accumulated in this vector.
- out_trunc  out  1  vector was terminated by MAX_LEN rather than by in_last.

Behaviour:
- Reset (rst_n=0 at a clock edge) has priority over everything. It sets:
  - state ACCUM;
  - all accumulators 0, out_data 0, out_ovf 0, out_count 0;
  - out_valid 0, out_trunc 0;
  - in_ready 1 on the cycle after the reset edge.
- Reset mid-vector or while a result is held discards all data.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - First beat of a vector (count==0): acc_i = sext(w_i*x_i); ovf cleared; sat_en latched.
  - Later beats: acc_i = acc_i + sext(w_i*x_i).
  - Each accepted beat increments count.
  - The beat is final if in_last=1 or count+1==MAX_LEN. The final beat moves the state to HOLD on the same edge. out_trunc = (count+1==MAX_LEN) && !in_last.
- Latency: the final beat is accepted at edge t. out_valid=1 from edge t, with out_data already including that final product. There are no extra pipeline stages.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_data, out_ovf, out_count and out_trunc are stable while out_ready=0.
  - When out_ready=1: return to ACCUM on that edge and zero count. in_ready=1 on the next cycle; there is no same-cycle pass-through.
- Arithmetic:
  - Product is full-precision signed 2*DW bits, sign-extended to AW.
  - The sum is computed at AW+1 bits. Overflow means the top two bits of the sum differ.
  - Wrap mode stores the low AW bits.
  - Saturating mode stores +(2^(AW-1)-1) or -2^(AW-1), according to the sign of the AW+1-bit sum.
  - Saturation applies per beat.
  - The lane's ovf is set on any overflow in either mode and stays set until the next vector's first beat.
- clear=1 (with rst_n=1) takes priority over beat acceptance and out_ready. It has the same effect as reset on state, counters, accumulators and outputs. A beat presented in the same cycle as clear is dropped.
- A single-beat vector (in_last on the first beat) is legal: the result is that single product and out_count=1.
- in_last=1 on the MAX_LEN-th beat: out_trunc=0.
- in_w, in_x, in_last and sat_en are ignored when no beat is accepted.

Test Plan:
- LANES=4, DW=8, AW=16, wrap mode. Lane0 gets w=3, x=4 for 3 beats, with in_last on beat 3; lanes 1-3 get w=-2, x=5. Required: out_data lanes = {36, -30, -30, -30}, out_count=3, ovf=0, out_valid on the same edge as beat 3 is accepted.
- Lane0 w=127, x=127 for 3 beats, sat_en=1: result 32767, out_ovf[0]=1. Same stimulus with sat_en=0: result -17149, out_ovf[0]=1. Lane with w=-128, x=127 for 3 beats: sat gives -32768, wrap gives 16768.
- Complete a vector, then hold out_ready=0 for 5 cycles while in_valid=1. Required: in_ready=0, out_data stable, no beats consumed. Raise out_ready: in_ready=1 next cycle, and the next vector starts from 0 with ovf cleared.
- MAX_LEN=4: send 6 beats of w=1, x=1 with no in_last. Required: first result 4, out_count=4, out_trunc=1. Beats 5-6 form a new vector after the handshake.
- Assert clear after 2 beats of a vector (w=5, x=5), then send 1 beat w=1, x=2 with in_last. Required: result 2, ovf=0, out_count=1. Repeat with rst_n=0 held for 1 cycle instead of clear: same result, and all outputs read 0 during reset.
- Single-beat vector w=-1, x=-1 with in_last: result 1 on every lane, out_count=1. Back-to-back vectors with out_ready tied high: one result every (beats+1) cycles.
